// File: rtl/shifter_pkg.sv
// Shared definitions for the shifter path: FSM state encoding and the
// rotate-direction constants used by the forward and inverse rotators.
package shifter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/rot1_step.sv
// Combinational single-position rotator.
// Right: out[i] = in[(i+1) mod WIDTH]; left: out[i] = in[(i-1) mod WIDTH].
module rot1_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in,
  input  logic             dir,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    if (dir == DIR_LEFT) begin
      out = {in[WIDTH-2:0], in[WIDTH-1]};
    end else begin
      out = {in[0], in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/inverse_rotator_seq.sv
// Sequential inverse rotator: undoes a forward rotation one bit per clock
// and presents the restored operand on dout with a start/busy/done handshake.
module inverse_rotator_seq
  import shifter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [SW-1:0]    amt,
  input  logic             r0_l1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] step;

  rot1_step #(.WIDTH(WIDTH)) u_step (
    .in  (work_q),
    .dir (dir_q),
    .out (step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_RIGHT;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      dout_q  <= dout_d;
    end
  end

  // The stored direction is already the inverse of the forward direction.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = din;
          cnt_d   = amt;
          dir_d   = (r0_l1 == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
          state_d = (amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        work_d = step;
        cnt_d  = cnt_q - SW'(1);
        if (cnt_d == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // dout only ever sees the finished result, latched as DONE is entered.
    if ((state_d == DONE) && (state_q != DONE)) begin
      dout_d = work_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign dout = dout_q;

endmodule

// File: tb/tb_inverse_rotator_seq.sv
// Directed bench for inverse_rotator_seq: reset, directed restores,
// ignore/abort behaviour and a full round trip against a forward model.
module tb_inverse_rotator_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] din;
  logic [1:0] amt;
  logic       r0_l1;
  logic       busy;
  logic       done;
  logic [3:0] dout;

  int vectors;
  int miscompares;

  inverse_rotator_seq #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .amt   (amt),
    .r0_l1 (r0_l1),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] rotR(input logic [3:0] v, input int a);
    int t;
    t = ({28'd0, v} >> a) | ({28'd0, v} << (4 - a));
    return t[3:0];
  endfunction

  function automatic logic [3:0] rotL(input logic [3:0] v, input int a);
    int t;
    t = ({28'd0, v} << a) | ({28'd0, v} >> (4 - a));
    return t[3:0];
  endfunction

  // Runs one operation; lat counts edges from the accepting edge (inclusive)
  // until done is first seen, busyCycles counts cycles with busy high.
  task automatic applyStimulus(input logic [3:0] d, input logic [1:0] a, input logic dir,
                               output int lat, output int busyCycles, output logic [3:0] res);
    @(negedge clk);
    din   = d;
    amt   = a;
    r0_l1 = dir;
    start = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    lat        = 0;
    busyCycles = 0;
    res        = 4'hx;
    for (int k = 0; k < int'(a) + 4; k++) begin
      if (busy) busyCycles++;
      if (done && lat == 0) begin
        lat = k + 1;
        res = dout;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int         lat;
    int         bc;
    logic [3:0] res;
    logic [3:0] fwd;

    vectors     = 0;
    miscompares = 0;
    rst   = 1'b0;
    start = 1'b1;
    din   = 4'hF;
    amt   = 2'd0;
    r0_l1 = 1'b0;

    // Reset held with start high: nothing may happen.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_dout", 32'(dout), 32'd0);
    start = 1'b0;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_dout", 32'(dout), 32'd0);

    // Directed restores.
    applyStimulus(4'b0001, 2'd1, 1'b0, lat, bc, res);
    checkOutput("left_dout", 32'(res), 32'b0010);
    checkOutput("left_lat", 32'(lat), 32'd2);

    applyStimulus(4'b1000, 2'd3, 1'b1, lat, bc, res);
    checkOutput("right_dout", 32'(res), 32'b0001);
    checkOutput("right_lat", 32'(lat), 32'd4);
    checkOutput("right_busy_cycles", 32'(bc), 32'd4);
    checkOutput("right_dout_held", 32'(dout), 32'b0001);

    applyStimulus(4'b1011, 2'd0, 1'b0, lat, bc, res);
    checkOutput("zero_dout", 32'(res), 32'b1011);
    checkOutput("zero_lat", 32'(lat), 32'd1);
    checkOutput("zero_busy_cycles", 32'(bc), 32'd1);

    // Second start and changed inputs while busy must be ignored.
    @(negedge clk);
    din = 4'b1000; amt = 2'd3; r0_l1 = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    din = 4'b1111; amt = 2'd0; r0_l1 = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("ign_not_done_early", 32'(done), 32'd0);
    @(posedge clk); #1;
    checkOutput("ign_done", 32'(done), 32'd1);
    checkOutput("ign_dout", 32'(dout), 32'b0001);
    @(posedge clk); #1;
    checkOutput("ign_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("ign_not_queued", 32'(busy), 32'd0);
    checkOutput("ign_dout_held", 32'(dout), 32'b0001);

    // Asynchronous abort two edges into an operation.
    @(negedge clk);
    din = 4'b0001; amt = 2'd3; r0_l1 = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_dout", 32'(dout), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(4'b0001, 2'd1, 1'b0, lat, bc, res);
    checkOutput("post_abort_dout", 32'(res), 32'b0010);
    checkOutput("post_abort_lat", 32'(lat), 32'd2);

    // Round trip through the forward rotator model.
    for (int v = 0; v < 16; v++) begin
      for (int a = 0; a < 4; a++) begin
        for (int d = 0; d < 2; d++) begin
          fwd = (d == 0) ? rotR(4'(v), a) : rotL(4'(v), a);
          applyStimulus(fwd, 2'(a), 1'(d), lat, bc, res);
          checkOutput($sformatf("rt_dout_v%0d_a%0d_d%0d", v, a, d), 32'(res), 32'(v));
          checkOutput($sformatf("rt_lat_v%0d_a%0d_d%0d", v, a, d), 32'(lat), 32'(a + 1));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
